// File: rtl/rr_arbiter.sv
// Round-robin arbiter granting one shared gate datapath to N requesters.
// Define ARB_TIMEOUT_EN to revoke grants held longer than MAX_HOLD cycles.
module rr_arbiter #(
  parameter int N        = 4,
  parameter int IDW      = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   done,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           busy,
  output logic           timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t         state, state_nxt;
  logic [IDW-1:0] last_id, last_id_nxt;
  logic [IDW-1:0] gnt_id_nxt;
  logic [N-1:0]   gnt_nxt;
  logic           busy_nxt, timeout_nxt;
  logic [IDW-1:0] sel, idx;
  logic           found;
  logic           release_now;
  logic           limit_hit;

  // Rotating priority search starting just after the most recent grantee.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IDW'((int'(last_id) + k) % N);
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  assign release_now = done[gnt_id] | ~req[gnt_id];

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt, hold_cnt_nxt;

  assign limit_hit    = (hold_cnt == HOLD_LAST);
  assign hold_cnt_nxt = (state == GRANT) ? hold_cnt + 8'd1 : 8'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_cnt <= 8'd0;
    else     hold_cnt <= hold_cnt_nxt;
  end
`else
  logic unused_hold;

  assign limit_hit   = 1'b0;
  assign unused_hold = ^HOLD_LAST;
`endif

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    gnt_id_nxt  = gnt_id;
    busy_nxt    = busy;
    last_id_nxt = last_id;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        gnt_nxt  = '0;
        busy_nxt = 1'b0;
        if (found) begin
          state_nxt  = GRANT;
          gnt_nxt    = N'(1) << sel;
          gnt_id_nxt = sel;
          busy_nxt   = 1'b1;
        end
      end
      GRANT: begin
        // A real release beats the hold limit, so timeout only flags a revocation.
        if (release_now || limit_hit) begin
          state_nxt   = IDLE;
          gnt_nxt     = '0;
          busy_nxt    = 1'b0;
          last_id_nxt = gnt_id;
          timeout_nxt = ~release_now;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      gnt_id  <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      last_id <= IDW'(N - 1);
    end else begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      state   <= state_nxt;
      gnt     <= gnt_nxt;
      gnt_id  <= gnt_id_nxt;
      busy    <= busy_nxt;
      timeout <= timeout_nxt;
      last_id <= last_id_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter: directed scenarios plus random traffic
// checked against a queue-free rotation model of the arbitration rules.
module tb_rr_arbiter;

  localparam int N        = 4;
  localparam int IDW      = 2;
  localparam int MAX_HOLD = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   done = '0;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;
  logic           timeout;

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the gate (-1 = nobody), who owned it last.
  int m_owner, m_last, m_hold, m_id;
  bit m_timeout;

  rr_arbiter #(.N(N), .IDW(IDW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_owner = -1; m_last = N - 1; m_hold = 0; m_id = 0; m_timeout = 0;
  endtask

  task automatic model_edge();
    m_timeout = 0;
    if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (m_last + k) % N;
        if (m_owner < 0 && req[i]) begin
          m_owner = i; m_id = i; m_hold = 0;
        end
      end
    end else if (done[m_owner] || !req[m_owner]) begin
      m_last = m_owner; m_owner = -1;
    end else begin
`ifdef ARB_TIMEOUT_EN
      if (m_hold == MAX_HOLD - 1) begin
        m_last = m_owner; m_owner = -1; m_timeout = 1;
      end else m_hold++;
`endif
    end
  endtask

  function automatic logic [N-1:0] model_gnt();
    logic [N-1:0] one = 1;
    return (m_owner < 0) ? '0 : one << m_owner;
  endfunction

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; req = '0; done = '0;
    #3;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (gnt !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL reset_idle: gnt=%b busy=%b want 0000/0", gnt, busy); end
    req = 4'b1111;
    step();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL reset_first_grant: gnt=%b want 0001", gnt); end
    step();
    #2 rst = 1'b1;
    #1;
    model_reset();
    total++; if (gnt !== 4'b0000 || gnt_id !== 2'd0 || busy !== 1'b0 || timeout !== 1'b0) begin
      bad++; $display("FAIL reset_async: gnt=%b id=%0d busy=%b to=%b want 0000/0/0/0", gnt, gnt_id, busy, timeout);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    total++; if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin bad++; $display("FAIL reset_regrant: gnt=%b id=%0d want 0001/0", gnt, gnt_id); end
  endtask

  task automatic test_single();
    req = 4'b0000;
    step();
    req = 4'b0100;
    for (int c = 1; c <= 3; c++) begin
      step();
      total++; if (gnt !== 4'b0100 || busy !== 1'b1) begin bad++; $display("FAIL single_hold%0d: gnt=%b busy=%b want 0100/1", c, gnt, busy); end
    end
    done = 4'b0100;
    step();
    done = 4'b0000;
    total++; if (gnt !== 4'b0000 || busy !== 1'b0 || gnt_id !== 2'd2) begin
      bad++; $display("FAIL single_release: gnt=%b busy=%b id=%0d want 0000/0/2", gnt, busy, gnt_id);
    end
    step();
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL single_regrant: gnt=%b want 0100", gnt); end
  endtask

  task automatic test_rotation();
    logic [N-1:0] exp_g;
    apply_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % N);
      step();
      total++; if (gnt !== exp_g) begin bad++; $display("FAIL rotation_grant%0d: gnt=%b want %b", k, gnt, exp_g); end
      step();
      done = gnt;
      step();
      done = '0;
      total++; if (gnt !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL rotation_dead%0d: gnt=%b busy=%b want 0000/0", k, gnt, busy); end
    end
  endtask

  task automatic test_ignored();
    apply_reset();
    req = 4'b0010;
    step();
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL ignored_grant: gnt=%b want 0010", gnt); end
    req  = 4'b0111;
    done = 4'b1101;
    step();
    step();
    done = 4'b0000;
    total++; if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin bad++; $display("FAIL ignored_spurious: gnt=%b id=%0d want 0010/1", gnt, gnt_id); end
    req = 4'b0101;
    step();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL ignored_drop: gnt=%b want 0000", gnt); end
    step();
    total++; if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin bad++; $display("FAIL ignored_next: gnt=%b id=%0d want 0100/2", gnt, gnt_id); end
  endtask

  task automatic test_hold();
    apply_reset();
    req = 4'b0010;
`ifdef ARB_TIMEOUT_EN
    for (int c = 1; c <= MAX_HOLD; c++) begin
      step();
      total++; if (gnt !== 4'b0010 || timeout !== 1'b0) begin bad++; $display("FAIL hold_cycle%0d: gnt=%b to=%b want 0010/0", c, gnt, timeout); end
    end
    step();
    total++; if (gnt !== 4'b0000 || timeout !== 1'b1) begin bad++; $display("FAIL hold_timeout: gnt=%b to=%b want 0000/1", gnt, timeout); end
    step();
    total++; if (gnt !== 4'b0010 || timeout !== 1'b0) begin bad++; $display("FAIL hold_regrant: gnt=%b to=%b want 0010/0", gnt, timeout); end
    for (int c = 2; c <= MAX_HOLD; c++) step();
    done = 4'b0010;
    step();
    done = 4'b0000;
    total++; if (gnt !== 4'b0000 || timeout !== 1'b0) begin bad++; $display("FAIL hold_done_wins: gnt=%b to=%b want 0000/0", gnt, timeout); end
`else
    for (int c = 1; c <= 120; c++) begin
      step();
      total++; if (gnt !== 4'b0010 || timeout !== 1'b0) begin bad++; $display("FAIL hold_cycle%0d: gnt=%b to=%b want 0010/0", c, gnt, timeout); end
    end
`endif
    req = 4'b0000;
    step();
  endtask

  task automatic test_random();
    logic [N-1:0] exp_g;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(7) == 0) req[i] = ~req[i];
        done[i] = ($urandom_range(5) == 0);
      end
      step();
      exp_g = model_gnt();
      total++;
      if (gnt !== exp_g || busy !== (m_owner >= 0) || gnt_id !== IDW'(m_id) || timeout !== m_timeout) begin
        bad++;
        $display("FAIL random_c%0d: gnt=%b id=%0d busy=%b to=%b want %b/%0d/%b/%b",
                 c, gnt, gnt_id, busy, timeout, exp_g, m_id, (m_owner >= 0), m_timeout);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_rotation();
    test_ignored();
    test_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
